fifo_ptr_ctrl: RTL and testbench

- Pointer and flag controller for the 16-entry, 8-bit register-file FIFO.
- Accepts push/pop requests and drives the 4-to-16 write-select decoder address and enable.
- Provides the read-mux select, plus full, empty and occupancy status.
- Sits between the FIFO client interface and the storage/decoder datapath. Storage itself is outside this block.

---
 rtl/fifo_ctrl_pkg.sv | 17 +
 rtl/fifo_ptr_cnt.sv | 35 +++
 rtl/fifo_ptr_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the 16-entry register-file FIFO controller.
// Holds the default geometry, the pointer/count types and an elaboration helper.
package fifo_ctrl_pkg;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  typedef logic [AW:0] ptr_t;
  typedef logic [AW:0] count_t;

  // True when the entry count matches the address space exactly.
  function automatic bit depth_ok(input int unsigned aw, input int unsigned depth);
    return depth == (32'd1 << aw);
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-around pointer counter for the FIFO controller.
// Ports:
//   clk - rising-edge clock
//   clr - synchronous clear, active-high, wins over inc
//   inc - advance the pointer by one (modulo 2**W)
//   q   - current pointer value
module fifo_ptr_cnt
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned W = $bits(ptr_t)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_d, cnt_q;

  // Natural overflow gives the wrap from all-ones back to zero.
  always_comb begin
    cnt_d = cnt_q + W'(inc);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for a 2**AW-entry register-file FIFO.
// Drives the write-select decoder and the read mux; the storage lives elsewhere.
// Optional almost-full/almost-empty flags are built when FIFO_CTRL_ALMOST_EN is defined.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   push, pop         - client requests
//   dec_addr, dec_en  - decoder write address and enable (same cycle as push)
//   rd_addr           - read-mux select for the head entry
//   full, empty       - occupancy flags
//   count             - occupancy 0..DEPTH
//   ovf, udf          - one-cycle pulses for a rejected push / pop
//   almost_full/empty - optional threshold flags
module fifo_ptr_ctrl #(
  parameter int unsigned AW       = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] dec_addr,
  output logic          dec_en,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  import fifo_ctrl_pkg::*;

  if (!depth_ok(AW, DEPTH)) begin : g_bad_depth
    $error("fifo_ptr_ctrl: DEPTH must equal 2**AW");
  end

  logic [AW:0] wr_ptr, rd_ptr;
  logic        push_acc, pop_acc;
  logic        ovf_q, udf_q;

  fifo_ptr_cnt #(
    .W (AW + 1)
  ) u_wr_ptr (
    .clk (clk),
    .clr (rst),
    .inc (push_acc),
    .q   (wr_ptr)
  );

  fifo_ptr_cnt #(
    .W (AW + 1)
  ) u_rd_ptr (
    .clk (clk),
    .clr (rst),
    .inc (pop_acc),
    .q   (rd_ptr)
  );

  always_comb begin
    count = wr_ptr - rd_ptr;
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    push_acc = push & (~full | pop);
    // No fall-through: an empty FIFO cannot pop the entry being pushed.
    pop_acc  = pop & ~empty;
  end

  assign dec_addr = wr_ptr[AW-1:0];
  assign dec_en   = push_acc & ~rst;
  assign rd_addr  = rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= push & ~push_acc;
      udf_q <= pop & ~pop_acc;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;

`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [AW:0] AfLevel = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AeLevel = (AW + 1)'(AE_LEVEL);

  logic [AW:0] count_d;
  logic        almost_full_q, almost_empty_q;

  // Registered from next-state occupancy so these move together with full/empty.
  always_comb begin
    count_d = count + (AW + 1)'(push_acc) - (AW + 1)'(pop_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= AfLevel);
      almost_empty_q <= (count_d <= AeLevel);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
module tb_fifo_ptr_ctrl;
  import fifo_ctrl_pkg::*;

  logic         clk;
  logic         rst;
  logic         push;
  logic         pop;
  logic [3:0]   dec_addr;
  logic         dec_en;
  logic [3:0]   rd_addr;
  logic         full;
  logic         empty;
  count_t       count;
  logic         ovf;
  logic         udf;
`ifdef FIFO_CTRL_ALMOST_EN
  logic         almost_full;
  logic         almost_empty;
`endif

  int total = 0;
  int bad   = 0;

  fifo_ptr_ctrl #(
    .AW       (4),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .dec_addr     (dec_addr),
    .dec_en       (dec_en),
    .rd_addr      (rd_addr),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf)
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    tick();
    tick();

    // Push during reset must not enable the decoder.
    push = 1'b1;
    #1;
    chk("dec_en_in_rst", 32'(dec_en), 32'd0);
    tick();
    push = 1'b0;
    rst  = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dec_addr", 32'(dec_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
`ifdef FIFO_CTRL_ALMOST_EN
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
`endif

    // Fill: 16 pushes, no pop.
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      #1;
      chk("fill_dec_en", 32'(dec_en), 32'd1);
      chk("fill_dec_addr", 32'(dec_addr), 32'(i));
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
`ifdef FIFO_CTRL_ALMOST_EN
      chk("fill_almost_full", 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      chk("fill_almost_empty", 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
`endif
    end
    push = 1'b0;
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);

    // 17th push is rejected.
    push = 1'b1;
    #1;
    chk("ovf_dec_en", 32'(dec_en), 32'd0);
    tick();
    push = 1'b0;
    #1;
    chk("ovf_pulse", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_dec_addr", 32'(dec_addr), 32'd0);
    tick();
    chk("ovf_clear", 32'(ovf), 32'd0);

    // Drain: 16 pops.
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      #1;
      chk("drain_rd_addr", 32'(rd_addr), 32'(i));
      tick();
      chk("drain_count", 32'(count), 32'(15 - i));
    end
    pop = 1'b0;
    #1;
    chk("drain_empty", 32'(empty), 32'd1);

    // 17th pop is rejected.
    pop = 1'b1;
    tick();
    pop = 1'b0;
    #1;
    chk("udf_pulse", 32'(udf), 32'd1);
    chk("udf_count", 32'(count), 32'd0);
    tick();
    chk("udf_clear", 32'(udf), 32'd0);

    // Wrap: alternate push/pop for 40 cycles; wr_ptr starts at 16 (low bits 0).
    for (int i = 0; i < 40; i++) begin
      push = (i % 2 == 0);
      pop  = (i % 2 == 1);
      #1;
      if (i % 2 == 0) chk("wrap_dec_addr", 32'(dec_addr), 32'((i / 2) % 16));
      tick();
      chk("wrap_count", 32'(count), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("wrap_full", 32'(full), 32'd0);
    end
    push = 1'b0;
    pop  = 1'b0;

    // Pointers now both at 36 mod 32 = 4. Fill again.
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      tick();
    end
    push = 1'b0;
    #1;
    chk("refill_full", 32'(full), 32'd1);

    // Full with simultaneous push and pop: both accepted.
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("fullpp_dec_en", 32'(dec_en), 32'd1);
    chk("fullpp_dec_addr", 32'(dec_addr), 32'd4);
    tick();
    push = 1'b0;
    pop  = 1'b0;
    #1;
    chk("fullpp_count", 32'(count), 32'd16);
    chk("fullpp_ovf", 32'(ovf), 32'd0);
    chk("fullpp_full", 32'(full), 32'd1);
    chk("fullpp_rd_addr", 32'(rd_addr), 32'd5);

    // Drain to empty (rd_ptr ends at 21, low bits 5).
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    #1;
    chk("redrain_empty", 32'(empty), 32'd1);

    // Empty with simultaneous push and pop: push only.
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("emptypp_dec_en", 32'(dec_en), 32'd1);
    chk("emptypp_rd_addr_pre", 32'(rd_addr), 32'd5);
    tick();
    push = 1'b0;
    pop  = 1'b0;
    #1;
    chk("emptypp_udf", 32'(udf), 32'd1);
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_rd_addr", 32'(rd_addr), 32'd5);
    chk("emptypp_empty", 32'(empty), 32'd0);

    // Clean reset, 5 pushes, then reset together with push.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      tick();
    end
    chk("pre_rst_count", 32'(count), 32'd5);
    rst  = 1'b1;
    push = 1'b1;
    #1;
    chk("midrst_dec_en", 32'(dec_en), 32'd0);
    tick();
    rst  = 1'b0;
    push = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_dec_addr", 32'(dec_addr), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
`ifdef FIFO_CTRL_ALMOST_EN
    chk("midrst_almost_empty", 32'(almost_empty), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
